// File: rtl/except_ctrl_pkg.sv
// Shared exception codes, raw exception-vector bit positions and control types.
package except_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned EXC_W  = 14;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned IRQ_W  = 8;

  // Cause.ExcCode values as written to CP0; EXC_NONE is an unused code.
  typedef enum logic [CODE_W-1:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12,
    EXC_NONE = 5'd31
  } exc_code_e;

  // Bit positions inside m1s_exc_vec; lower index wins.
  localparam int unsigned EB_ADEL_F     = 0;
  localparam int unsigned EB_ITLB_REF   = 1;
  localparam int unsigned EB_ITLB_INV   = 2;
  localparam int unsigned EB_RI         = 3;
  localparam int unsigned EB_OV         = 4;
  localparam int unsigned EB_SYS        = 5;
  localparam int unsigned EB_BP         = 6;
  localparam int unsigned EB_ADEL_D     = 7;
  localparam int unsigned EB_ADES       = 8;
  localparam int unsigned EB_DTLB_RREF  = 9;
  localparam int unsigned EB_DTLB_RINV  = 10;
  localparam int unsigned EB_DTLB_WREF  = 11;
  localparam int unsigned EB_DTLB_WINV  = 12;
  localparam int unsigned EB_DTLB_MOD   = 13;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Winner of the priority encoder.
  typedef struct packed {
    exc_code_e code;
    logic      refill;
    logic      any;
  } exc_sel_t;

  // Map a raw exception bit to its shared ExcCode.
  function automatic exc_code_e bit_code(input int unsigned idx);
    case (idx)
      EB_ADEL_F, EB_ADEL_D:                       bit_code = EXC_ADEL;
      EB_ITLB_REF, EB_ITLB_INV,
      EB_DTLB_RREF, EB_DTLB_RINV:                 bit_code = EXC_TLBL;
      EB_DTLB_WREF, EB_DTLB_WINV:                 bit_code = EXC_TLBS;
      EB_DTLB_MOD:                                bit_code = EXC_MOD;
      EB_RI:                                      bit_code = EXC_RI;
      EB_OV:                                      bit_code = EXC_OV;
      EB_SYS:                                     bit_code = EXC_SYS;
      EB_BP:                                      bit_code = EXC_BP;
      EB_ADES:                                    bit_code = EXC_ADES;
      default:                                    bit_code = EXC_NONE;
    endcase
  endfunction

  // TLB refill bits use the dedicated refill vector when EXL=0.
  function automatic logic is_refill(input int unsigned idx);
    is_refill = (idx == EB_ITLB_REF) || (idx == EB_DTLB_RREF) || (idx == EB_DTLB_WREF);
  endfunction

endpackage

// File: rtl/except_ctrl_if.sv
// MEM-stage / CP0 / fetch-redirect signal bundle around the exception controller.
interface except_ctrl_if;
  import except_ctrl_pkg::*;

  logic              m1s_valid;
  logic [XLEN-1:0]   m1s_pc;
  logic              m1s_bd;
  logic [EXC_W-1:0]  m1s_exc_vec;
  logic              m1s_inst_eret;
  logic              cp0_status_ie;
  logic              cp0_status_exl;
  logic [IRQ_W-1:0]  cp0_status_im;
  logic [IRQ_W-1:0]  cp0_cause_ip;
  logic [XLEN-1:0]   cp0_epc;
  logic              m1s_ex;
  logic [CODE_W-1:0] exctype;
  logic              m1s_eret;
  logic              flush;
  logic              redirect_valid;
  logic              redirect_ready;
  logic [XLEN-1:0]   redirect_pc;

  modport master (
    output m1s_valid, m1s_pc, m1s_bd, m1s_exc_vec, m1s_inst_eret,
    output cp0_status_ie, cp0_status_exl, cp0_status_im, cp0_cause_ip, cp0_epc,
    output redirect_ready,
    input  m1s_ex, exctype, m1s_eret, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  m1s_valid, m1s_pc, m1s_bd, m1s_exc_vec, m1s_inst_eret,
    input  cp0_status_ie, cp0_status_exl, cp0_status_im, cp0_cause_ip, cp0_epc,
    input  redirect_ready,
    output m1s_ex, exctype, m1s_eret, flush, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/except_ctrl_exc_prio_enc.sv
// 15-to-1 priority encoder: interrupt first, then lowest raw exception bit.
module exc_prio_enc
  import except_ctrl_pkg::*;
(
  input  logic             int_pending,
  input  logic [EXC_W-1:0] exc_vec,
  output exc_sel_t         sel
);

  // Pick the first set exception bit, then let a pending interrupt override it.
  always_comb begin
    sel = '{code: EXC_NONE, refill: 1'b0, any: 1'b0};
    for (int unsigned i = 0; i < EXC_W; i++) begin
      if (exc_vec[i] && !sel.any) begin
        sel.code   = bit_code(i);
        sel.refill = is_refill(i);
        sel.any    = 1'b1;
      end
    end
    if (int_pending) begin
      sel.code   = EXC_INT;
      sel.refill = 1'b0;
      sel.any    = 1'b1;
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception/ERET commit, pipeline flush and fetch-redirect handshake.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EX_VEC     = 32'hbfc00380,
  parameter logic [31:0] REFILL_VEC = 32'hbfc00200
) (
  input  logic          clk,
  input  logic          resetn,
  except_ctrl_if.slave  bus
);

  logic            int_req;
  logic            int_pending;
  state_e          state_q, state_d;
  logic            rv_q, rv_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic            ex, eret;
  exc_sel_t        sel;

  // PC and delay-slot flag are consumed by CP0 for EPC/BD, not by this control.
  logic unused_pipe;
  assign unused_pipe = ^{bus.m1s_pc, bus.m1s_bd};

  assign int_req = bus.cp0_status_ie & ~bus.cp0_status_exl
                 & (|(bus.cp0_status_im & bus.cp0_cause_ip));

  // Interrupt request sampled every cycle; seen by the next MEM instruction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) int_pending <= 1'b0;
    else         int_pending <= int_req;
  end

  exc_prio_enc u_prio_enc (
    .int_pending (int_pending),
    .exc_vec     (bus.m1s_exc_vec),
    .sel         (sel)
  );

  // State and redirect registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
    end
  end

  // Commit decision in IDLE; hold the redirect until fetch accepts it.
  always_comb begin
    state_d = state_q;
    rv_d    = rv_q;
    rpc_d   = rpc_q;
    ex      = 1'b0;
    eret    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (resetn && bus.m1s_valid) begin
          ex   = sel.any;
          eret = bus.m1s_inst_eret & ~sel.any;
          if (ex || eret) begin
            state_d = ST_HOLD;
            rv_d    = 1'b1;
            if (eret)                                rpc_d = bus.cp0_epc;
            else if (sel.refill && !bus.cp0_status_exl) rpc_d = REFILL_VEC;
            else                                     rpc_d = EX_VEC;
          end
        end
      end
      ST_HOLD: begin
        if (bus.redirect_ready) begin
          state_d = ST_IDLE;
          rv_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.m1s_ex         = ex;
  assign bus.m1s_eret       = eret;
  assign bus.flush          = ex | eret;
  assign bus.exctype        = ex ? sel.code : EXC_NONE;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;

endmodule

// File: tb/tb_except_ctrl.sv
// Bench for except_ctrl: literal vectors, corner sequences and a random run vs a model.
module tb_except_ctrl;

  localparam logic [31:0] EXV = 32'hbfc00380;
  localparam logic [31:0] RFV = 32'hbfc00200;
  localparam logic [4:0]  NOX = 5'd31;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  except_ctrl_if bus();

  except_ctrl #(.EX_VEC(EXV), .REFILL_VEC(RFV)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_hold, m_rv, m_intp;
  logic [31:0] m_rpc;
  logic [4:0]  code_of [14] = '{5'd4, 5'd2, 5'd2, 5'd10, 5'd12, 5'd8, 5'd9,
                                 5'd4, 5'd5, 5'd2, 5'd2, 5'd3, 5'd3, 5'd1};

  typedef struct {
    logic [13:0] vec;
    bit          eret;
    bit          exl;
    logic [31:0] epc;
    bit          x_ex;
    logic [4:0]  x_code;
    bit          x_eret;
    logic [31:0] x_rpc;
  } tv_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected combinational outputs from the current inputs and model state.
  task automatic model_eval(output bit ex, output logic [4:0] code, output bit eret,
                            output logic [31:0] tgt);
    int  first;
    bit  take;
    first = -1;
    ex = 0; eret = 0; code = NOX; tgt = '0;
    if (resetn === 1'b1 && !m_hold && bus.m1s_valid) begin
      for (int i = 13; i >= 0; i--) if (bus.m1s_exc_vec[i]) first = i;
      take = m_intp || (first >= 0);
      ex   = take;
      eret = bus.m1s_inst_eret && !take;
      if (m_intp)          code = 5'd0;
      else if (first >= 0) code = code_of[first];
      if (eret) tgt = bus.cp0_epc;
      else if (!m_intp && (first == 1 || first == 9 || first == 11) && !bus.cp0_status_exl)
        tgt = RFV;
      else tgt = EXV;
    end
  endtask

  // Called at the falling edge: check everything, advance one clock, update model.
  task automatic cycle();
    bit          ex, eret, ireq;
    logic [4:0]  code;
    logic [31:0] tgt;
    model_eval(ex, code, eret, tgt);
    chk("m1s_ex",         32'(bus.m1s_ex),         32'(ex));
    chk("exctype",        32'(bus.exctype),        32'(code));
    chk("m1s_eret",       32'(bus.m1s_eret),       32'(eret));
    chk("flush",          32'(bus.flush),          32'(ex | eret));
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
    chk("redirect_pc",    bus.redirect_pc,         m_rpc);
    ireq = bus.cp0_status_ie && !bus.cp0_status_exl && (|(bus.cp0_status_im & bus.cp0_cause_ip));
    @(posedge clk);
    if (resetn !== 1'b1) begin
      m_hold = 0; m_rv = 0; m_rpc = '0; m_intp = 0;
    end else begin
      m_intp = ireq;
      if (m_hold) begin
        if (bus.redirect_ready) begin m_hold = 0; m_rv = 0; end
      end else if (ex || eret) begin
        m_hold = 1; m_rv = 1; m_rpc = tgt;
      end
    end
    #1;
  endtask

  task automatic step();
    #4;
    cycle();
  endtask

  task automatic idle_inputs();
    bus.m1s_valid = 0; bus.m1s_exc_vec = '0; bus.m1s_inst_eret = 0;
    bus.cp0_status_ie = 0; bus.cp0_status_exl = 0;
    bus.cp0_status_im = '0; bus.cp0_cause_ip = '0;
    bus.redirect_ready = 0;
  endtask

  tv_t tv [11];

  initial begin
    tv[0]  = '{14'h0028, 0, 0, 32'h0,        1, 5'd10, 0, EXV};
    tv[1]  = '{14'h0000, 1, 0, 32'hbfc01234, 0, NOX,   1, 32'hbfc01234};
    tv[2]  = '{14'h0010, 1, 0, 32'hbfc01234, 1, 5'd12, 0, EXV};
    tv[3]  = '{14'h0002, 0, 0, 32'h0,        1, 5'd2,  0, RFV};
    tv[4]  = '{14'h0002, 0, 1, 32'h0,        1, 5'd2,  0, EXV};
    tv[5]  = '{14'h0081, 0, 0, 32'h0,        1, 5'd4,  0, EXV};
    tv[6]  = '{14'h0800, 0, 0, 32'h0,        1, 5'd3,  0, RFV};
    tv[7]  = '{14'h2000, 0, 0, 32'h0,        1, 5'd1,  0, EXV};
    tv[8]  = '{14'h0100, 0, 0, 32'h0,        1, 5'd5,  0, EXV};
    tv[9]  = '{14'h0600, 0, 0, 32'h0,        1, 5'd2,  0, RFV};
    tv[10] = '{14'h1040, 0, 0, 32'h0,        1, 5'd9,  0, EXV};

    resetn = 0;
    bus.m1s_pc = 32'h8000_0000; bus.m1s_bd = 0; bus.cp0_epc = '0;
    idle_inputs();
    m_hold = 0; m_rv = 0; m_rpc = '0; m_intp = 0;
    #2;
    chk("reset redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("reset redirect_pc",    bus.redirect_pc,         32'd0);
    @(posedge clk); #1;
    step();
    resetn = 1;
    step();

    // Table vectors from IDLE
    foreach (tv[k]) begin
      bus.m1s_valid = 1; bus.m1s_exc_vec = tv[k].vec; bus.m1s_inst_eret = tv[k].eret;
      bus.cp0_status_exl = tv[k].exl; bus.cp0_epc = tv[k].epc;
      #4;
      chk($sformatf("tv%0d m1s_ex", k),   32'(bus.m1s_ex),   32'(tv[k].x_ex));
      chk($sformatf("tv%0d exctype", k),  32'(bus.exctype),  32'(tv[k].x_code));
      chk($sformatf("tv%0d m1s_eret", k), 32'(bus.m1s_eret), 32'(tv[k].x_eret));
      cycle();
      idle_inputs();
      #4;
      chk($sformatf("tv%0d redirect_valid", k), 32'(bus.redirect_valid), 32'd1);
      chk($sformatf("tv%0d redirect_pc", k),    bus.redirect_pc,         tv[k].x_rpc);
      cycle();
      bus.redirect_ready = 1;
      step();
      bus.redirect_ready = 0;
      step();
    end

    // Interrupt seen one cycle earlier beats AdES
    bus.cp0_status_ie = 1; bus.cp0_status_im = 8'h80; bus.cp0_cause_ip = 8'h80;
    step();
    step();
    bus.m1s_valid = 1; bus.m1s_exc_vec = 14'h0100;
    #4;
    chk("int over AdES exctype", 32'(bus.exctype), 32'd0);
    cycle();
    idle_inputs();
    bus.redirect_ready = 1;
    step();
    bus.redirect_ready = 0;
    step();

    // Long HOLD with an exception applied throughout
    bus.m1s_valid = 1; bus.m1s_exc_vec = 14'h0040;
    step();
    for (int i = 0; i < 5; i++) begin
      #4;
      chk("hold m1s_ex",          32'(bus.m1s_ex),         32'd0);
      chk("hold redirect_valid",  32'(bus.redirect_valid), 32'd1);
      chk("hold redirect_pc",     bus.redirect_pc,         EXV);
      cycle();
    end
    bus.redirect_ready = 1;
    step();
    bus.redirect_ready = 0;
    #4;
    chk("post-hold idle m1s_ex", 32'(bus.m1s_ex),         32'd1);
    chk("post-hold valid drop",  32'(bus.redirect_valid), 32'd0);
    cycle();

    // Reset in the middle of HOLD
    #1;
    resetn = 0;
    #1;
    chk("reset-in-hold redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("reset-in-hold m1s_ex",         32'(bus.m1s_ex),         32'd0);
    m_hold = 0; m_rv = 0; m_rpc = '0; m_intp = 0;
    #2;
    cycle();
    resetn = 1;
    #4;
    chk("after reset idle m1s_ex", 32'(bus.m1s_ex), 32'd1);
    cycle();
    idle_inputs();
    bus.redirect_ready = 1;
    step();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.m1s_valid      = ($urandom_range(0, 3) != 0);
      bus.m1s_exc_vec    = ($urandom_range(0, 2) == 0) ? 14'($urandom) & 14'($urandom) : 14'h0;
      bus.m1s_inst_eret  = ($urandom_range(0, 3) == 0);
      bus.cp0_status_ie  = $urandom_range(0, 1) == 1;
      bus.cp0_status_exl = $urandom_range(0, 2) == 0;
      bus.cp0_status_im  = 8'($urandom);
      bus.cp0_cause_ip   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      bus.cp0_epc        = $urandom;
      bus.m1s_pc         = $urandom;
      bus.redirect_ready = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 Parameters (name, default, meaning): EX_VEC 32'hbfc00380 general exception target; REFILL_VEC 32'hbfc00200 TLB-refill target when EXL=0.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 m1s_valid  in  1  MEM-stage instruction valid.
REQ-005 m1s_pc  in  32  MEM-stage PC.
REQ-006 m1s_bd  in  1  MEM-stage instruction sits in a delay slot.
REQ-007 m1s_exc_vec  in  14  raw exception flags; bit0 AdEL-fetch, 1 ITLB refill, 2 ITLB invalid, 3 RI, 4 Ov, 5 Sys, 6 Bp, 7 AdEL-data, 8 AdES, 9 DTLB rd refill, 10 DTLB rd invalid, 11 DTLB wr refill, 12 DTLB wr invalid, 13 DTLB modified.
REQ-008 m1s_inst_eret  in  1  MEM-stage instruction is ERET.
REQ-009 cp0_status_ie / cp0_status_exl  in  1 each  Status.IE / Status.EXL.
REQ-010 cp0_status_im / cp0_cause_ip  in  8 each  Status.IM / Cause.IP.
REQ-011 cp0_epc  in  32  EPC value.
REQ-012 m1s_ex  out  1  exception commit strobe to CP0.
REQ-013 exctype  out  5  exception code to CP0.
REQ-014 m1s_eret  out  1  ERET commit strobe to CP0.
REQ-015 flush  out  1  kill all stages up to and including MEM.
REQ-016 redirect_valid / redirect_ready  out / in  1 each  fetch redirect handshake.
REQ-017 redirect_pc  out  32  fetch redirect target.

Function
REQ-018 int_req = IE & ~EXL & |(IM & IP); int_pending SHALL register int_req every cycle (one-cycle latency).
REQ-019 States: IDLE, HOLD; reset enters IDLE.
REQ-020 In IDLE with m1s_valid=1: take = int_pending | (|m1s_exc_vec); m1s_ex = take, combinational, same cycle.
REQ-021 Priority: Int highest, then m1s_exc_vec lowest index first; exactly one exctype driven via shared codes; bits 0 and 7 both map to AdEL.
REQ-022 exctype SHALL be NO_EX when m1s_ex=0.
REQ-023 m1s_eret = m1s_valid & m1s_inst_eret & ~take in IDLE; exception wins over ERET.
REQ-024 flush = m1s_ex | m1s_eret, same cycle.
REQ-025 Target: ERET -> cp0_epc; TLB refill (bits 1, 9, 11) with EXL=0 -> REFILL_VEC; otherwise EX_VEC.
REQ-026 On flush: register target into redirect_pc, assert redirect_valid next cycle, go HOLD.
REQ-027 HOLD: redirect_valid and redirect_pc stable until redirect_ready=1; the cycle ready=1 is sampled, valid drops next cycle and state returns to IDLE.
REQ-028 HOLD: m1s_ex, m1s_eret, flush forced 0 regardless of inputs (wrong-path instructions).
REQ-029 redirect_ready=1 while in IDLE SHALL be ignored.
REQ-030 m1s_valid=0: no ex, no eret, no flush; int_pending remains and is taken at the next valid instruction.

Reset
REQ-031 On resetn=0 (any cycle, incl. mid-HOLD): state IDLE, redirect_valid 0, redirect_pc 0, int_pending 0; m1s_ex, m1s_eret, flush, exctype=NO_EX follow with no input effect.

Structure
REQ-032 Exception codes (Int, AdEL, AdES, Sys, Bp, RI, Ov, ITLB_*, DTLB_*, NO_EX) and exc_vec bit positions SHALL live in global_defines.vh, shared with CP0_Reg.
REQ-033 One sub-module natural: exc_prio_enc (combinational 15-to-1 priority encoder producing exctype and refill flag).

Verification
REQ-034 m1s_exc_vec=14'h0028 (RI+Sys), valid, EXL=0 -> m1s_ex=1, exctype=RI, next cycle redirect_valid=1, redirect_pc=32'hbfc00380.
REQ-035 IE=1, EXL=0, IM=8'h80, IP=8'h80 one cycle before a valid instr with exc_vec=14'h0100 -> exctype=Int, not AdES.
REQ-036 Valid ERET with cp0_epc=32'hbfc01234 and no exc -> m1s_eret=1, flush=1, redirect_pc=32'hbfc01234; same with exc_vec bit4 -> m1s_ex=1, m1s_eret=0.
REQ-037 exc_vec bit1, EXL=0 -> redirect_pc=32'hbfc00200; EXL=1 -> 32'hbfc00380.
REQ-038 redirect_ready held 0 for 5 cycles with exc_vec=14'h0040 applied throughout -> redirect_valid/pc stable, m1s_ex=0 in HOLD; ready=1 -> IDLE next cycle.
REQ-039 resetn dropped while in HOLD -> redirect_valid=0 immediately, IDLE after release.
